// File: rtl/approx_adder_rr_arbiter.sv
// Two-requester round-robin front end for one shared, externally instantiated adder.
// Operands are registered and applied to the adder; the raw sum is returned tagged with the owner.
module approx_adder_rr_arbiter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] adder_in1,
   output logic [WIDTH-1:0] adder_in2,
   input  logic [WIDTH:0]   adder_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH:0]   rsp_sum,
   output logic             rsp_id,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             op_id_q, op_id_d;
   logic             last_q, last_d;
   logic [WIDTH:0]   rsp_sum_q, rsp_sum_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_valid_q, rsp_valid_d;

   logic accept_en;
   logic grant;
   logic handshake;

   // Ready depends only on the valids and the pointer, never on the other ready.
   always_comb begin
      accept_en = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
      if (req0_valid && req1_valid) begin
         grant = ~last_q;
      end else begin
         grant = req1_valid;
      end
      req0_ready = accept_en && req0_valid && !grant;
      req1_ready = accept_en && req1_valid && grant;
      handshake  = req0_ready || req1_ready;
   end

   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_id_d     = op_id_q;
      last_d      = last_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;

      case (state_q)
         StIdle: begin
            state_d = StIdle;
         end
         StIssue: begin
            state_d     = StResp;
            rsp_sum_d   = adder_out;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A handshake can only occur in IDLE or a retiring RESP; it overrides the IDLE target.
      if (handshake) begin
         op_a_d  = grant ? req1_a : req0_a;
         op_b_d  = grant ? req1_b : req0_b;
         op_id_d = grant;
         last_d  = grant;
         state_d = StIssue;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_id_q     <= 1'b0;
         last_q      <= 1'b1;
         rsp_sum_q   <= '0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_id_q     <= op_id_d;
         last_q      <= last_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign adder_in1 = op_a_q;
   assign adder_in2 = op_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != StIdle);

endmodule
